mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage initiator that drives the word-addressed data memory's `address`/`WD`/`WE`/`RD` interface on behalf of the pipeline. It converts LB/LBU/LH/LHU/LW/SB/SH/SW requests into word-aligned memory transactions. Sub-word stores use a two-cycle read-modify-write with a one-cycle pipeline stall. It also detects misaligned accesses and counts them.

Parameters:
BIG_ENDIAN, 1, byte 0 of a word is bits 31:24 when 1; bits 7:0 when 0
ERR_CNT_W, 8, width of the saturating misaligned-access counter

Ports:
clock  in  1  system clock; memory samples on negedge, this block updates state on posedge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  MEM-stage access request (load or store)
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word)
req_unsigned  in  1  zero-extend loads (LBU/LHU); ignored for stores and words
req_addr  in  32  byte address (ALUOutM)
req_wdata  in  32  store data, right-justified (WriteDataM)
mem_rd  in  32  memory read data (`RD`)
mem_addr  out  32  word-aligned address to memory, {req_addr[31:2],2'b00}
mem_wd  out  32  write data to memory
mem_we  out  1  memory write enable
load_data  out  32  extracted, sign/zero-extended load result
stall  out  1  holds IF/ID/EX/MEM registers while high
misaligned  out  1  pulses high for a misaligned request in its cycle
err_count  out  ERR_CNT_W  saturating count of misaligned requests

Behaviour:
- States: IDLE, RMW_READ, RMW_WRITE. Reset (async, reset_n=0): state=IDLE, merge_q=0, err_count=0; mem_we=0, stall=0, misaligned=0, load_data=0 immediately.
- Alignment rules: half is misaligned if addr[0]=1; word is misaligned if addr[1:0]!=0; byte is never misaligned.
- Misaligned request (any state entry from IDLE): misaligned=1, mem_we=0, load_data=0, no stall, and the request is not performed. err_count increments at posedge and saturates at all-ones.
- Loads, in IDLE, aligned:
  - mem_we=0; memory returns RD at negedge, and load_data is valid combinationally before the next posedge. Zero latency, no stall.
  - Lane select uses addr[1:0] under the BIG_ENDIAN mapping.
  - Sign-extend unless req_unsigned.
- SW, aligned: mem_we=1 and mem_wd=req_wdata in the same cycle, no stall.
- SB/SH, aligned, IDLE → RMW_READ:
  - stall=1 and mem_we=0 while in RMW_READ.
  - At posedge, merge_q ← mem_rd with the target lane replaced by req_wdata[7:0] or [15:0], and state → RMW_WRITE.
- RMW_WRITE: mem_we=1, mem_wd=merge_q, stall=0; then → IDLE at next posedge. Total: 2 cycles, 1 stall cycle.
- Request stability: the pipeline holds the request stable while stall=1.
- Abort: if req_valid drops in RMW_READ, go to IDLE with no write.
- Reset during RMW_READ/RMW_WRITE: immediate return to IDLE; the write is suppressed even within the same cycle.
- Back-to-back sub-word stores: after RMW_WRITE, a new SB/SH re-enters RMW_READ. The read is never bypassed from merge_q; memory holds the updated word after the negedge write.
- mem_addr is always word-aligned, including during RMW.
- Outputs are a combinational function of state, the request, and mem_rd. No glitch requirement beyond stability at negedge.

Decomposition:
- Shared package mem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings
  - RMW state encoding
  - STACK/TEXT_DAT address bounds constants
- One sub-module, mem_lane_align, is combinational and does two things:
  - Load extract: rd, offset, size, unsigned → data.
  - Store merge: rd, wdata, offset, size → word.
- The FSM and counter stay in mem_access_unit.

Test Plan:
- Memory word 0x80223344 at 0x0040_0010, BIG_ENDIAN=1:
  - LB 0x0040_0011 → load_data 0x00000022.
  - LB 0x0040_0010 → 0xFFFFFF80.
  - LBU 0x0040_0010 → 0x00000080.
  - LHU 0x0040_0012 → 0x00003344.
  - No stall in any of these cases.
- SB 0x000000AB to 0x0040_0012 (word 0x11223344) → stall=1 for one cycle with mem_we=0. Next cycle mem_we=1, mem_wd=0x1122AB44. Word then reads 0x1122AB44.
- SH 0x0000BEEF to 0x0040_0010, then immediately SB 0x00000055 to 0x0040_0013 → 0xBEEF3344, then 0xBEEF3355, with two separate stall cycles.
- SW 0xDEADBEEF to 0x0040_0014 → mem_we=1 in the same cycle, stall=0. LW 0x0040_0012 → misaligned=1, mem_we=0, err_count=1. 256 further misaligned requests → err_count=0xFF.
- Async reset asserted mid-cycle in RMW_READ of an SB → stall and mem_we fall immediately, state=IDLE, target word unchanged.
- req_valid dropped during RMW_READ → no write occurs and the next cycle is in IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, RMW sequencer
// states and the memory-map bounds used by the surrounding pipeline.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RMW_READ  = 2'd1;
    localparam logic [1:0] ST_RMW_WRITE = 2'd2;

    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE = 32'h1001_0000;
    localparam logic [31:0] STACK_TOP = 32'h7FFF_EFFC;

    // Bytes never fault; halves need bit 0 clear; words (and reserved) need both clear.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            default:   bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a 32-bit memory word and sub-word accesses:
// extracts and extends load lanes, and splices store data into a read word.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] rd,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data,
    output logic [31:0] word
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [31:0] byte_word;
    logic [31:0] half_word;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Big-endian places byte 0 in the top lane, so the shift counts from the MSB side.
    always_comb begin
        byte_shift = BIG_ENDIAN ? {~offset, 3'b000} : {offset, 3'b000};
        half_shift = BIG_ENDIAN ? {~offset[1], 4'b0000} : {offset[1], 4'b0000};
        byte_word  = rd >> byte_shift;
        half_word  = rd >> half_shift;
        byte_val   = byte_word[7:0];
        half_val   = half_word[15:0];
    end

    always_comb begin
        data = rd;
        case (size)
            SIZE_BYTE: data = is_unsigned ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
            SIZE_HALF: data = is_unsigned ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
            default:   data = rd;
        endcase
    end

    always_comb begin
        word = wdata;
        case (size)
            SIZE_BYTE: word = (rd & ~(32'h0000_00FF << byte_shift))
                            | ({24'h0, wdata[7:0]} << byte_shift);
            SIZE_HALF: word = (rd & ~(32'h0000_FFFF << half_shift))
                            | ({16'h0, wdata[15:0]} << half_shift);
            default:   word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: zero-latency loads, single-cycle word stores,
// two-cycle read-modify-write for byte/half stores, misaligned detection and count.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [31:0]          mem_rd,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wd,
    output logic                 mem_we,
    output logic [31:0]          load_data,
    output logic                 stall,
    output logic                 misaligned,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]           state_reg, state_next;
    logic [1:0]           phase;
    logic [31:0]          merge_reg, merge_next;
    logic [ERR_CNT_W-1:0] err_reg;
    logic                 req_bad;
    logic                 sub_store;
    logic [31:0]          lane_load;
    logic [31:0]          lane_merge;

    assign mem_addr  = {req_addr[31:2], 2'b00};
    assign err_count = err_reg;
    assign req_bad   = is_misaligned(req_size, req_addr[1:0]);
    assign sub_store = req_valid && req_write && !req_bad
                    && (req_size == SIZE_BYTE || req_size == SIZE_HALF);

    // The read half of an RMW occupies the request's own first cycle, so a
    // sub-word store entering from IDLE is handled as RMW_READ right away.
    assign phase = (state_reg == ST_IDLE && sub_store) ? ST_RMW_READ : state_reg;

    mem_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .rd          (mem_rd),
        .wdata       (req_wdata),
        .offset      (req_addr[1:0]),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .data        (lane_load),
        .word        (lane_merge)
    );

    always_comb begin
        state_next = state_reg;
        merge_next = merge_reg;
        mem_we     = 1'b0;
        mem_wd     = req_wdata;
        stall      = 1'b0;
        load_data  = 32'h0;
        misaligned = 1'b0;
        case (phase)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        misaligned = 1'b1;
                    end else if (!req_write) begin
                        load_data = lane_load;
                    end else begin
                        mem_we = 1'b1;
                    end
                end
            end
            ST_RMW_READ: begin
                if (req_valid) begin
                    stall      = 1'b1;
                    merge_next = lane_merge;
                    state_next = ST_RMW_WRITE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RMW_WRITE: begin
                mem_we     = 1'b1;
                mem_wd     = merge_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Reset must silence the memory strobe within the same cycle.
        if (!reset_n) begin
            mem_we     = 1'b0;
            stall      = 1'b0;
            misaligned = 1'b0;
            load_data  = 32'h0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            merge_reg <= 32'h0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            merge_reg <= merge_next;
            if (misaligned && err_reg != {ERR_CNT_W{1'b1}}) begin
                err_reg <= err_reg + ERR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a small negedge-sampled word memory;
// big-endian lanes, hand-computed expectations.
module tb_mem_access_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] load_data;
    logic        stall;
    logic        misaligned;
    logic [7:0]  err_count;

    logic [31:0] mem [0:15];
    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_access_unit #(
        .BIG_ENDIAN (1'b1),
        .ERR_CNT_W  (8)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_wd       (mem_wd),
        .mem_we       (mem_we),
        .load_data    (load_data),
        .stall        (stall),
        .misaligned   (misaligned),
        .err_count    (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Word memory: writes and read-data update on the falling edge.
    always @(negedge clock) begin
        if (mem_we) mem[mem_addr[5:2]] <= mem_wd;
        mem_rd <= mem[mem_addr[5:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %s: %h", tag, obs);
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid    = v;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
    endtask

    task automatic to_pos();
        @(posedge clock);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        mem_rd  = 32'h0;
        drive(1, 1, 2'b00, 0, 32'h0040_0012, 32'h0000_00AB);
        #1;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mis", {31'h0, misaligned}, 32'h0);
        chk("rst_load", load_data, 32'h0);
        chk("rst_err", {24'h0, err_count}, 32'h0);

        to_pos();
        reset_n = 1'b1;
        drive(0, 0, 2'b10, 0, 32'h0, 32'h0);

        // Seed word 0x0040_0010 through a word store.
        to_pos();
        drive(1, 1, 2'b10, 0, 32'h0040_0010, 32'h8022_3344);
        to_neg();
        chk("sw_seed_we", {31'h0, mem_we}, 32'h1);
        chk("sw_seed_wd", mem_wd, 32'h8022_3344);

        to_pos(); drive(1, 0, 2'b00, 0, 32'h0040_0011, 32'h0);
        to_neg();
        chk("lb_11", load_data, 32'h0000_0022);
        chk("lb_11_stall", {31'h0, stall}, 32'h0);
        chk("lb_addr", mem_addr, 32'h0040_0010);
        to_pos(); drive(1, 0, 2'b00, 0, 32'h0040_0010, 32'h0);
        to_neg();
        chk("lb_10", load_data, 32'hFFFF_FF80);
        to_pos(); drive(1, 0, 2'b00, 1, 32'h0040_0010, 32'h0);
        to_neg();
        chk("lbu_10", load_data, 32'h0000_0080);
        to_pos(); drive(1, 0, 2'b01, 1, 32'h0040_0012, 32'h0);
        to_neg();
        chk("lhu_12", load_data, 32'h0000_3344);
        chk("lhu_12_stall", {31'h0, stall}, 32'h0);
        to_pos(); drive(1, 0, 2'b01, 0, 32'h0040_0010, 32'h0);
        to_neg();
        chk("lh_10", load_data, 32'hFFFF_8022);

        // SB into byte 2 of 0x11223344.
        to_pos(); drive(1, 1, 2'b10, 0, 32'h0040_0010, 32'h1122_3344);
        to_pos(); drive(1, 1, 2'b00, 0, 32'h0040_0012, 32'h0000_00AB);
        #1;
        chk("sb_rd_stall", {31'h0, stall}, 32'h1);
        chk("sb_rd_we", {31'h0, mem_we}, 32'h0);
        chk("sb_rd_addr", mem_addr, 32'h0040_0010);
        to_pos();
        chk("sb_wr_stall", {31'h0, stall}, 32'h0);
        chk("sb_wr_we", {31'h0, mem_we}, 32'h1);
        to_neg();
        chk("sb_wr_wd", mem_wd, 32'h1122_AB44);
        to_pos(); drive(1, 0, 2'b10, 0, 32'h0040_0010, 32'h0);
        to_neg();
        chk("sb_readback", load_data, 32'h1122_AB44);

        // SH then back-to-back SB.
        to_pos(); drive(1, 1, 2'b10, 0, 32'h0040_0010, 32'h1122_3344);
        to_pos(); drive(1, 1, 2'b01, 0, 32'h0040_0010, 32'h0000_BEEF);
        #1;
        chk("sh_rd_stall", {31'h0, stall}, 32'h1);
        to_pos();
        chk("sh_wr_we", {31'h0, mem_we}, 32'h1);
        chk("sh_wr_wd", mem_wd, 32'hBEEF_3344);
        to_pos(); drive(1, 1, 2'b00, 0, 32'h0040_0013, 32'h0000_0055);
        #1;
        chk("sb2_rd_stall", {31'h0, stall}, 32'h1);
        chk("sb2_rd_we", {31'h0, mem_we}, 32'h0);
        to_pos();
        chk("sb2_wr_we", {31'h0, mem_we}, 32'h1);
        chk("sb2_wr_wd", mem_wd, 32'hBEEF_3355);
        to_pos(); drive(1, 0, 2'b10, 0, 32'h0040_0010, 32'h0);
        to_neg();
        chk("sb2_readback", load_data, 32'hBEEF_3355);

        to_pos(); drive(1, 1, 2'b10, 0, 32'h0040_0014, 32'hDEAD_BEEF);
        #1;
        chk("sw_we", {31'h0, mem_we}, 32'h1);
        chk("sw_stall", {31'h0, stall}, 32'h0);
        chk("sw_wd", mem_wd, 32'hDEAD_BEEF);

        to_pos(); drive(1, 0, 2'b10, 0, 32'h0040_0012, 32'h0);
        to_neg();
        chk("lw_mis", {31'h0, misaligned}, 32'h1);
        chk("lw_mis_we", {31'h0, mem_we}, 32'h0);
        chk("lw_mis_load", load_data, 32'h0);
        chk("lw_mis_stall", {31'h0, stall}, 32'h0);
        to_pos();
        chk("err_one", {24'h0, err_count}, 32'h1);

        for (int i = 0; i < 256; i++) begin
            if (i % 2 == 0) drive(1, 0, 2'b01, 0, 32'h0040_0011, 32'h0);
            else            drive(1, 1, 2'b10, 0, 32'h0040_0016, 32'h1234_5678);
            to_neg();
            if (i == 0) chk("lh_mis", {31'h0, misaligned}, 32'h1);
            if (i == 1) chk("sw_mis_we", {31'h0, mem_we}, 32'h0);
            to_pos();
            if (i == 199) chk("err_201", {24'h0, err_count}, 32'h0000_00C9);
        end
        chk("err_sat", {24'h0, err_count}, 32'h0000_00FF);

        // Async reset in the RMW read cycle.
        drive(1, 1, 2'b00, 0, 32'h0040_0010, 32'h0000_0077);
        #1;
        chk("rst_rmw_pre", {31'h0, stall}, 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_rmw_stall", {31'h0, stall}, 32'h0);
        chk("rst_rmw_we", {31'h0, mem_we}, 32'h0);
        chk("rst_rmw_err", {24'h0, err_count}, 32'h0);
        to_neg();
        to_pos();
        reset_n = 1'b1;
        drive(1, 0, 2'b10, 0, 32'h0040_0010, 32'h0);
        #1;
        chk("rst_idle_stall", {31'h0, stall}, 32'h0);
        to_neg();
        chk("rst_word_kept", load_data, 32'hBEEF_3355);

        // Abort: req_valid drops during the read cycle.
        to_pos(); drive(1, 1, 2'b00, 0, 32'h0040_0013, 32'h0000_0099);
        #1;
        chk("abort_stall", {31'h0, stall}, 32'h1);
        to_neg();
        req_valid = 1'b0;
        #1;
        chk("abort_drop_stall", {31'h0, stall}, 32'h0);
        to_pos();
        chk("abort_no_we", {31'h0, mem_we}, 32'h0);
        to_pos(); drive(1, 0, 2'b10, 0, 32'h0040_0010, 32'h0);
        to_neg();
        chk("abort_word_kept", load_data, 32'hBEEF_3355);
        to_pos(); drive(1, 0, 2'b10, 0, 32'h0040_0014, 32'h0);
        to_neg();
        chk("sw_readback", load_data, 32'hDEAD_BEEF);

        to_pos(); drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
